ifetch_ctrl: RTL and testbench

Fetch sequencer between the front-end PC, the instruction cache request/response port, and the instruction buffer. Generates sequential 8-byte-aligned fetch requests and throttles them on buffer space and outstanding-request credit. Tags each request with its PC and slot count, and drives the buffer's write port from cache responses. On a backend redirect it discards stale in-flight responses.

---
 rtl/ifetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: sequential fetch sequencer between front-end PC, I-cache port and instruction buffer.
// Optional macro IFETCH_ADEF_CHECK_EN enables the misaligned-redirect fetch-address exception.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ibuf_flush,
    input  logic        ibuf_input_ready,
    output logic [1:0]  ibuf_input_size,
    output logic [31:0] ibuf_pc1,
    output logic [31:0] ibuf_inst1,
    output logic [31:0] ibuf_pc2,
    output logic [31:0] ibuf_inst2,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_inst1,
    input  logic [31:0] icache_resp_inst2,
    output logic        fetch_adef
);
    localparam logic [1:0] MAX_CNT  = 2'(MAX_OUTSTANDING);
    localparam logic       PTR_LAST = 1'(MAX_OUTSTANDING - 1);

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  drop_cnt;
    logic [1:0]  resp_dec;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        adef;
    logic        req_fire;
    logic        fwd;
    logic        redir_load;
    logic [31:0] redir_target;
    logic [31:0] meta_pc [2];
    logic [1:0]  meta_size [2];
    logic [31:0] head_pc;
    logic [1:0]  head_size;

`ifdef IFETCH_ADEF_CHECK_EN
    assign redir_load   = (redirect_pc[1:0] == 2'b00);
    assign redir_target = redirect_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adef <= 1'b0;
        end else if (redirect_valid) begin
            adef <= !redir_load;
        end
    end
`else
    assign redir_load   = 1'b1;
    assign redir_target = redirect_pc & ~32'd3;
    assign adef         = 1'b0;
`endif

    assign ibuf_flush       = redirect_valid;
    assign fetch_adef       = adef;
    assign icache_req_addr  = fetch_pc;
    // Held low while in reset so the cache sees no request before it is released.
    assign icache_req_valid = resetn && !redirect_valid && !adef && ibuf_input_ready &&
                              (outstanding < MAX_CNT);
    assign req_fire         = icache_req_valid && icache_req_ready;
    assign resp_dec         = {1'b0, icache_resp_valid};

    assign head_pc   = meta_pc[rd_ptr];
    assign head_size = meta_size[rd_ptr];
    assign fwd       = icache_resp_valid && (drop_cnt == 2'd0) && !redirect_valid;

    // The cache returns an aligned 8-byte block; an odd-word PC uses its upper word only.
    always_comb begin
        ibuf_input_size = 2'd0;
        ibuf_pc1        = 32'd0;
        ibuf_inst1      = 32'd0;
        ibuf_pc2        = 32'd0;
        ibuf_inst2      = 32'd0;
        if (fwd) begin
            ibuf_input_size = head_size;
            ibuf_pc1        = head_pc;
            if (head_size == 2'd2) begin
                ibuf_inst1 = icache_resp_inst1;
                ibuf_pc2   = head_pc + 32'd4;
                ibuf_inst2 = icache_resp_inst2;
            end else begin
                ibuf_inst1 = icache_resp_inst2;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            if (redir_load) begin
                fetch_pc <= redir_target;
            end
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + (fetch_pc[2] ? 32'd4 : 32'd8);
        end
    end

    // Stale entries stay in the meta FIFO; drop_cnt marks how many at the head to discard.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else if (redirect_valid) begin
            outstanding <= outstanding - resp_dec;
            drop_cnt    <= outstanding - resp_dec;
        end else begin
            outstanding <= outstanding + {1'b0, req_fire} - resp_dec;
            if (icache_resp_valid && (drop_cnt != 2'd0)) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (req_fire) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? 1'b0 : ~wr_ptr;
            end
            if (icache_resp_valid) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? 1'b0 : ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            meta_pc[wr_ptr]   <= fetch_pc;
            meta_size[wr_ptr] <= fetch_pc[2] ? 2'd1 : 2'd2;
        end
    end

    resp_needs_entry: assert property (@(posedge clk) disable iff (!resetn)
        icache_resp_valid |-> (outstanding != 2'd0));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: in-order cache model plus a queue-based reference of in-flight fetches.
// Define IFETCH_ADEF_CHECK_EN for both files to cover the misaligned-redirect exception.
module tb_ifetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          MAXO     = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        ibuf_flush;
    logic        ibuf_input_ready = 1'b0;
    logic [1:0]  ibuf_input_size;
    logic [31:0] ibuf_pc1, ibuf_inst1, ibuf_pc2, ibuf_inst2;
    logic        icache_req_valid;
    logic        icache_req_ready = 1'b0;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid = 1'b0;
    logic [31:0] icache_resp_inst1 = 32'd0;
    logic [31:0] icache_resp_inst2 = 32'd0;
    logic        fetch_adef;

    ifetch_ctrl #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ibuf_flush(ibuf_flush), .ibuf_input_ready(ibuf_input_ready),
        .ibuf_input_size(ibuf_input_size),
        .ibuf_pc1(ibuf_pc1), .ibuf_inst1(ibuf_inst1), .ibuf_pc2(ibuf_pc2), .ibuf_inst2(ibuf_inst2),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_addr(icache_req_addr), .icache_resp_valid(icache_resp_valid),
        .icache_resp_inst1(icache_resp_inst1), .icache_resp_inst2(icache_resp_inst2),
        .fetch_adef(fetch_adef)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  size;
        bit          live;
        int          due;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    int          lat_min = 2, lat_max = 2, ready_pct = 100, resp_pct = 100;
    logic [31:0] m_pc = RESET_PC;
    bit          m_adef = 1'b0;
    int          n_cmp = 0, n_fail = 0;

    logic        e_req_valid = 1'b0, e_flush = 1'b0, e_adef = 1'b0;
    logic [31:0] e_req_addr = RESET_PC;
    logic [1:0]  e_size = 2'd0;
    logic [31:0] e_pc1 = 32'd0, e_inst1 = 32'd0, e_pc2 = 32'd0, e_inst2 = 32'd0;
    logic [164:0] exp_vec, dut_vec;

    assign exp_vec = {e_req_valid, e_req_addr, e_size, e_pc1, e_inst1, e_pc2, e_inst2, e_flush, e_adef};
    assign dut_vec = {icache_req_valid, icache_req_addr, ibuf_input_size,
                      (e_size != 2'd0) ? ibuf_pc1 : 32'd0, (e_size != 2'd0) ? ibuf_inst1 : 32'd0,
                      (e_size == 2'd2) ? ibuf_pc2 : 32'd0, (e_size == 2'd2) ? ibuf_inst2 : 32'd0,
                      ibuf_flush, fetch_adef};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[31:16]};
    endfunction

    // Reference: every accepted request is a queue entry; a redirect kills everything in flight.
    initial begin : model
        bit          s_acc, s_resp, s_redir;
        logic [31:0] s_redir_pc, blk;
        ent_t        e;
        forever begin
            @(negedge clk);
            s_acc = 0; s_resp = 0; s_redir = 0; s_redir_pc = 32'd0;
            e_size = 2'd0; e_pc1 = 32'd0; e_inst1 = 32'd0; e_pc2 = 32'd0; e_inst2 = 32'd0;
            if (!resetn) begin
                e_req_valid = 1'b0; e_req_addr = RESET_PC; e_flush = 1'b0; e_adef = 1'b0;
            end else begin
                e_flush     = redirect_valid;
                e_adef      = m_adef;
                e_req_valid = !redirect_valid && !m_adef && ibuf_input_ready && (q.size() < MAXO);
                e_req_addr  = m_pc;
                if (icache_resp_valid && q.size() > 0 && q[0].live && !redirect_valid) begin
                    e_size  = q[0].size;
                    e_pc1   = q[0].pc;
                    e_inst1 = word_at(q[0].pc);
                    if (q[0].size == 2'd2) begin
                        e_pc2   = q[0].pc + 32'd4;
                        e_inst2 = word_at(q[0].pc + 32'd4);
                    end
                end
                s_acc      = e_req_valid && icache_req_ready;
                s_resp     = icache_resp_valid;
                s_redir    = redirect_valid;
                s_redir_pc = redirect_pc;
            end
            @(posedge clk);
            cyc++;
            if (!resetn) begin
                q.delete();
                m_pc   = RESET_PC;
                m_adef = 1'b0;
            end else begin
                if (s_resp && q.size() > 0) void'(q.pop_front());
                if (s_acc) begin
                    e.pc   = m_pc;
                    e.size = m_pc[2] ? 2'd1 : 2'd2;
                    e.live = 1'b1;
                    e.due  = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
                    q.push_back(e);
                    m_pc = m_pc + (m_pc[2] ? 32'd4 : 32'd8);
                end
                if (s_redir) begin
                    foreach (q[i]) q[i].live = 1'b0;
`ifdef IFETCH_ADEF_CHECK_EN
                    if (s_redir_pc[1:0] != 2'b00) m_adef = 1'b1;
                    else begin m_adef = 1'b0; m_pc = s_redir_pc; end
`else
                    m_pc = {s_redir_pc[31:2], 2'b00};
`endif
                end
            end
            #1;
            icache_req_ready = ($urandom_range(99) < ready_pct);
            if (resetn && q.size() > 0 && q[0].due <= cyc && $urandom_range(99) < resp_pct) begin
                blk = q[0].pc & ~32'd7;
                icache_resp_valid = 1'b1;
                icache_resp_inst1 = word_at(blk);
                icache_resp_inst2 = word_at(blk + 32'd4);
            end else begin
                icache_resp_valid = 1'b0;
                icache_resp_inst1 = $urandom;
                icache_resp_inst2 = $urandom;
            end
        end
    end

    task automatic test_reset();
        lat_min = 2; lat_max = 2; ready_pct = 100; resp_pct = 100;
        resetn = 1'b0; ibuf_input_ready = 1'b1; redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (icache_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", icache_req_valid); end
        n_cmp++; if (icache_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr got %h want %h", icache_req_addr, RESET_PC); end
        n_cmp++; if (ibuf_input_size !== 2'd0) begin n_fail++; $display("FAIL reset_size got %0d want 0", ibuf_input_size); end
        n_cmp++; if ({ibuf_flush, fetch_adef} !== 2'b00) begin n_fail++; $display("FAIL reset_flush_adef got %b want 00", {ibuf_flush, fetch_adef}); end
        n_cmp++; if ({ibuf_pc1, ibuf_inst1, ibuf_pc2, ibuf_inst2} !== 128'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {ibuf_pc1, ibuf_inst1, ibuf_pc2, ibuf_inst2}); end
        @(posedge clk); #2;
        resetn = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if ({icache_req_valid, icache_req_addr} !== {1'b1, RESET_PC}) begin n_fail++; $display("FAIL first_req got %b/%h want 1/%h", icache_req_valid, icache_req_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_acc = RESET_PC + 32'd8;
        logic [31:0] exp_wr  = RESET_PC;
        int outs = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL seq_vec cyc %0d got %h want %h", cyc, dut_vec, exp_vec); end
            if (icache_req_valid && icache_req_ready) begin
                n_cmp++; if (icache_req_addr !== exp_acc) begin n_fail++; $display("FAIL seq_addr got %h want %h", icache_req_addr, exp_acc); end
                exp_acc += 32'd8;
                outs++;
            end
            if (icache_resp_valid) begin
                n_cmp++; if ({ibuf_input_size, ibuf_pc1, ibuf_pc2} !== {2'd2, exp_wr, exp_wr + 32'd4}) begin
                    n_fail++; $display("FAIL seq_write got %0d/%h/%h want 2/%h/%h", ibuf_input_size, ibuf_pc1, ibuf_pc2, exp_wr, exp_wr + 32'd4);
                end
                exp_wr += 32'd8;
                outs--;
            end
            n_cmp++; if (outs > MAXO) begin n_fail++; $display("FAIL seq_outstanding got %0d want <=%0d", outs, MAXO); end
        end
    endtask

    task automatic test_redirect_unaligned();
        logic [31:0] a = 32'h1c000104;
        int n_acc = 0;
        bit got_wr = 0;
        @(posedge clk); #2;
        redirect_valid = 1'b1; redirect_pc = a;
        for (int i = 0; i < 40 && !(got_wr && n_acc >= 2); i++) begin
            @(negedge clk); #1;
            n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL unal_vec cyc %0d got %h want %h", cyc, dut_vec, exp_vec); end
            if (i == 0) begin
                n_cmp++; if ({icache_req_valid, ibuf_flush} !== 2'b01) begin n_fail++; $display("FAIL unal_redir_cycle got %b want 01", {icache_req_valid, ibuf_flush}); end
            end
            if (i == 1) begin
                n_cmp++; if (icache_req_addr !== a) begin n_fail++; $display("FAIL unal_next_addr got %h want %h", icache_req_addr, a); end
            end
            if (icache_req_valid && icache_req_ready && n_acc < 2) begin
                n_cmp++; if (icache_req_addr !== ((n_acc == 0) ? a : 32'h1c000108)) begin n_fail++; $display("FAIL unal_acc%0d got %h", n_acc, icache_req_addr); end
                n_acc++;
            end
            if (!got_wr && ibuf_input_size != 2'd0) begin
                got_wr = 1;
                n_cmp++; if ({ibuf_input_size, ibuf_pc1, ibuf_inst1} !== {2'd1, a, word_at(a)}) begin
                    n_fail++; $display("FAIL unal_write got %0d/%h/%h want 1/%h/%h", ibuf_input_size, ibuf_pc1, ibuf_inst1, a, word_at(a));
                end
            end
            if (i == 0) begin @(posedge clk); #2; redirect_valid = 1'b0; end
        end
        n_cmp++; if (!(got_wr && n_acc >= 2)) begin n_fail++; $display("FAIL unal_timeout got wr=%0d acc=%0d want 1/2", got_wr, n_acc); end
    endtask

    task automatic test_stale();
        logic [31:0] t = 32'h1c000200;
        int w = 0, dropped = 0;
        bit got_wr = 0;
        lat_min = 4; lat_max = 4;
        do begin @(posedge clk); #2; w++; end while (q.size() != 2 && w < 40);
        n_cmp++; if (q.size() != 2) begin n_fail++; $display("FAIL stale_setup got %0d in flight want 2", q.size()); end
        redirect_valid = 1'b1; redirect_pc = t;
        for (int i = 0; i < 40 && !got_wr; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL stale_vec cyc %0d got %h want %h", cyc, dut_vec, exp_vec); end
            if (icache_resp_valid && ibuf_input_size == 2'd0) dropped++;
            if (ibuf_input_size != 2'd0) begin
                got_wr = 1;
                n_cmp++; if ({ibuf_pc1, 8'(dropped)} !== {t, 8'd2}) begin n_fail++; $display("FAIL stale_first got pc %h dropped %0d want %h 2", ibuf_pc1, dropped, t); end
            end
            if (i == 0) begin @(posedge clk); #2; redirect_valid = 1'b0; end
        end
        n_cmp++; if (!got_wr) begin n_fail++; $display("FAIL stale_timeout got no write want pc %h", t); end
        lat_min = 2; lat_max = 2;
    endtask

    task automatic test_redirect_with_resp();
        logic [31:0] t = 32'h1c000300;
        int w = 0, seen = 0;
        do begin @(posedge clk); #2; w++; end while (!(icache_resp_valid && q.size() == 2) && w < 40);
        n_cmp++; if (!(icache_resp_valid && q.size() == 2)) begin n_fail++; $display("FAIL rwr_setup got resp=%b inflight=%0d want 1/2", icache_resp_valid, q.size()); end
        redirect_valid = 1'b1; redirect_pc = t;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rwr_vec cyc %0d got %h want %h", cyc, dut_vec, exp_vec); end
            if (i == 0) begin
                n_cmp++; if (ibuf_input_size !== 2'd0) begin n_fail++; $display("FAIL rwr_same_cycle got %0d want 0", ibuf_input_size); end
            end else begin
                if (i == 1) begin
                    n_cmp++; if (dut.drop_cnt !== 2'd1) begin n_fail++; $display("FAIL rwr_drop_cnt got %0d want 1", dut.drop_cnt); end
                end
                if (icache_resp_valid) begin
                    seen++;
                    n_cmp++;
                    if (seen == 1 && ibuf_input_size !== 2'd0) begin n_fail++; $display("FAIL rwr_second got %0d want 0", ibuf_input_size); end
                    if (seen == 2 && {ibuf_input_size, ibuf_pc1} !== {2'd2, t}) begin n_fail++; $display("FAIL rwr_third got %0d/%h want 2/%h", ibuf_input_size, ibuf_pc1, t); end
                end
            end
            if (i == 0) begin @(posedge clk); #2; redirect_valid = 1'b0; end
        end
        n_cmp++; if (seen < 2) begin n_fail++; $display("FAIL rwr_timeout got %0d responses want 2", seen); end
    endtask

    task automatic test_ibuf_stall();
        int w = 0, live = 0, writes = 0;
        do begin @(posedge clk); #2; w++; end while (q.size() != 2 && w < 40);
        foreach (q[i]) if (q[i].live) live++;
        ibuf_input_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (icache_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req cyc %0d got 1 want 0", cyc); end
            if (ibuf_input_size != 2'd0) writes++;
        end
        n_cmp++; if (writes != live || live == 0) begin n_fail++; $display("FAIL stall_writes got %0d want %0d (nonzero)", writes, live); end
        @(posedge clk); #2;
        ibuf_input_ready = 1'b1;
    endtask

`ifdef IFETCH_ADEF_CHECK_EN
    task automatic test_adef();
        bit resumed = 0;
        @(posedge clk); #2;
        redirect_valid = 1'b1; redirect_pc = 32'h1c000002;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++; if ({fetch_adef, icache_req_valid} !== 2'b10) begin n_fail++; $display("FAIL adef_set got %b want 10", {fetch_adef, icache_req_valid}); end
            if (i < 3) @(posedge clk);
        end
        @(posedge clk); #2;
        redirect_valid = 1'b1; redirect_pc = 32'h1c000000;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (fetch_adef !== 1'b0) begin n_fail++; $display("FAIL adef_clear got 1 want 0"); end
        for (int i = 0; i < 12 && !resumed; i++) begin
            if (icache_req_valid && icache_req_ready) begin
                resumed = 1;
                n_cmp++; if (icache_req_addr !== 32'h1c000000) begin n_fail++; $display("FAIL adef_resume got %h want 1c000000", icache_req_addr); end
            end
            if (!resumed) begin @(negedge clk); #1; end
        end
        n_cmp++; if (!resumed) begin n_fail++; $display("FAIL adef_timeout got no request want one"); end
    endtask
`endif

    task automatic test_random();
        lat_min = 1; lat_max = 4; ready_pct = 70; resp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            ibuf_input_ready = ($urandom_range(99) < 80);
            redirect_valid   = ($urandom_range(99) < 5);
            redirect_pc      = ($urandom_range(9) == 0) ? (32'hfffffff8 | ($urandom & 32'h7))
                                                        : (32'h1c000000 | ($urandom & 32'h00000fff));
            @(negedge clk); #1;
            n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rand_vec cyc %0d got %h want %h", cyc, dut_vec, exp_vec); end
        end
        @(posedge clk); #2;
        redirect_valid = 1'b0; ibuf_input_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_unaligned();
        test_stale();
        test_redirect_with_resp();
        test_ibuf_stall();
`ifdef IFETCH_ADEF_CHECK_EN
        test_adef();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
